fetch_unit: RTL and testbench

Instruction fetch stage directly downstream of the program counter. It latches the current PC value, issues a single-outstanding read to instruction memory over a req/gnt/rvalid handshake, and loads the returned word into the instruction register. It pulses pcinc back to the program counter and presents opcode and operand fields to the controller under a valid/ack handshake. A flush input, driven by a taken branch or pcload, discards any in-flight fetch.

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: latches the PC, performs one outstanding memory
// read over a req/gnt/rvalid handshake and holds the returned word in the
// instruction register until the controller acknowledges it.
module fetch_unit #(
  parameter int unsigned AW  = 16,
  parameter int unsigned IW  = 16,
  parameter int unsigned OPW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     pc_addr,
  input  logic              fetch_en,
  input  logic              flush,
  output logic              mem_req,
  output logic [AW-1:0]     mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [IW-1:0]     mem_rdata,
  output logic              pcinc,
  output logic [IW-1:0]     ir,
  output logic [OPW-1:0]    opcode,
  output logic [IW-OPW-1:0] operand,
  output logic              ir_valid,
  input  logic              ir_ack,
  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StHold
  } state_e;

  state_e          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            pcinc_q, pcinc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic            ir_valid_q, ir_valid_d;
  // Set when the granted read must be discarded on arrival.
  logic            drop_q, drop_d;

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      pcinc_q    <= 1'b0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      pcinc_q    <= pcinc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      drop_q     <= drop_d;
    end
  end

  // Next-state and next-output logic for the fetch sequence.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    pcinc_d    = 1'b0;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    drop_d     = drop_q;

    unique case (state_q)
      StIdle: begin
        if (fetch_en && !flush) begin
          mem_addr_d = pc_addr;
          mem_req_d  = 1'b1;
          state_d    = StReq;
        end
      end

      StReq: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = StWait;
          // A flush in the grant cycle cannot retract the read, so mark it
          // for discard instead of advancing the PC.
          if (flush) begin
            drop_d = 1'b1;
          end else begin
            pcinc_d = 1'b1;
          end
        end else if (flush) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end
      end

      StWait: begin
        if (flush) begin
          drop_d = 1'b1;
        end
        if (mem_rvalid) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = StIdle;
          end else begin
            ir_d       = mem_rdata;
            ir_valid_d = 1'b1;
            state_d    = StHold;
          end
        end
      end

      StHold: begin
        if (flush) begin
          ir_valid_d = 1'b0;
          state_d    = StIdle;
        end else if (ir_ack) begin
          ir_valid_d = 1'b0;
          if (fetch_en) begin
            mem_addr_d = pc_addr;
            mem_req_d  = 1'b1;
            state_d    = StReq;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign pcinc    = pcinc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign opcode   = ir_q[IW-1:IW-OPW];
  assign operand  = ir_q[IW-OPW-1:0];
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue scoreboard of expected
// instruction words.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] pc_addr;
  logic        fetch_en;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        pcinc;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic [11:0] operand;
  logic        ir_valid;
  logic        ir_ack;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  fetch_unit #(
    .AW  (16),
    .IW  (16),
    .OPW (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_addr    (pc_addr),
    .fetch_en   (fetch_en),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .pcinc      (pcinc),
    .ir         (ir),
    .opcode     (opcode),
    .operand    (operand),
    .ir_valid   (ir_valid),
    .ir_ack     (ir_ack),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for ir_valid, then pop the scoreboard and compare.
  task automatic check_ir();
    int n;
    logic [15:0] e;
    n = 0;
    while (ir_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    if (ir_valid !== 1'b1 || exp_q.size() == 0) begin
      chk("ir_valid_wait", 32'(ir_valid), 32'd1);
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("ir", 32'(ir), 32'(e));
      chk("opcode", 32'(opcode), 32'(e[15:12]));
      chk("operand", 32'(operand), 32'(e[11:0]));
    end
  endtask

  initial begin
    rst        = 1'b1;
    pc_addr    = '0;
    fetch_en   = 1'b0;
    flush      = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    ir_ack     = 1'b0;
    tick();
    tick();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_irv", 32'(ir_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Basic fetch at minimum latency.
    pc_addr  = 16'h0010;
    fetch_en = 1'b1;
    tick();
    chk("b_req", 32'(mem_req), 32'd1);
    chk("b_addr", 32'(mem_addr), 32'h10);
    chk("b_pcinc0", 32'(pcinc), 32'd0);
    fetch_en = 1'b0;
    mem_gnt  = 1'b1;
    tick();
    chk("b_pcinc1", 32'(pcinc), 32'd1);
    chk("b_req_drop", 32'(mem_req), 32'd0);
    chk("b_busy", 32'(busy), 32'd1);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hA123;
    exp_q.push_back(16'hA123);
    tick();
    mem_rvalid = 1'b0;
    chk("b_irv_c3", 32'(ir_valid), 32'd1);
    chk("b_pcinc_once", 32'(pcinc), 32'd0);
    chk("b_opcode", 32'(opcode), 32'hA);
    chk("b_operand", 32'(operand), 32'h123);
    check_ir();
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    chk("b_ack_irv", 32'(ir_valid), 32'd0);
    chk("b_ack_busy", 32'(busy), 32'd0);

    // Memory stall: gnt 3 cycles late, rvalid 4 cycles after gnt.
    pc_addr  = 16'h0020;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    pc_addr  = 16'h0021;
    for (int i = 0; i < 3; i++) begin
      chk("s_req_hold", 32'(mem_req), 32'd1);
      chk("s_addr_hold", 32'(mem_addr), 32'h20);
      chk("s_no_pcinc", 32'(pcinc), 32'd0);
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("s_pcinc", 32'(pcinc), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s_wait_pcinc", 32'(pcinc), 32'd0);
      chk("s_wait_irv", 32'(ir_valid), 32'd0);
      chk("s_wait_busy", 32'(busy), 32'd1);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h5A5A;
    exp_q.push_back(16'h5A5A);
    tick();
    mem_rvalid = 1'b0;
    chk("s_irv", 32'(ir_valid), 32'd1);
    check_ir();
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;

    // Flush while waiting for data.
    pc_addr  = 16'h0030;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    mem_gnt  = 1'b1;
    tick();
    mem_gnt = 1'b0;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hFFFF;
    tick();
    mem_rvalid = 1'b0;
    chk("fw_irv", 32'(ir_valid), 32'd0);
    chk("fw_ir", 32'(ir), 32'h5A5A);
    chk("fw_busy", 32'(busy), 32'd0);
    pc_addr  = 16'h0040;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("fw_next_addr", 32'(mem_addr), 32'h40);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h1234;
    exp_q.push_back(16'h1234);
    tick();
    mem_rvalid = 1'b0;
    check_ir();
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;

    // Flush coincident with grant.
    pc_addr  = 16'h0050;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    mem_gnt  = 1'b1;
    flush    = 1'b1;
    tick();
    mem_gnt = 1'b0;
    flush   = 1'b0;
    chk("fg_no_pcinc", 32'(pcinc), 32'd0);
    chk("fg_req", 32'(mem_req), 32'd0);
    chk("fg_busy_wait", 32'(busy), 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hBEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("fg_busy", 32'(busy), 32'd0);
    chk("fg_irv", 32'(ir_valid), 32'd0);
    chk("fg_ir", 32'(ir), 32'h1234);

    // Back-to-back fetch on acknowledge, then flush with acknowledge.
    pc_addr  = 16'h0060;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    mem_gnt  = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h7001;
    exp_q.push_back(16'h7001);
    tick();
    mem_rvalid = 1'b0;
    check_ir();
    pc_addr  = 16'h0011;
    fetch_en = 1'b1;
    ir_ack   = 1'b1;
    tick();
    ir_ack   = 1'b0;
    fetch_en = 1'b0;
    chk("bb_req", 32'(mem_req), 32'd1);
    chk("bb_addr", 32'(mem_addr), 32'h11);
    chk("bb_irv", 32'(ir_valid), 32'd0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("bb_pcinc", 32'(pcinc), 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h8002;
    exp_q.push_back(16'h8002);
    tick();
    mem_rvalid = 1'b0;
    check_ir();
    pc_addr  = 16'h0012;
    fetch_en = 1'b1;
    ir_ack   = 1'b1;
    flush    = 1'b1;
    tick();
    fetch_en = 1'b0;
    ir_ack   = 1'b0;
    flush    = 1'b0;
    chk("bf_req", 32'(mem_req), 32'd0);
    chk("bf_irv", 32'(ir_valid), 32'd0);
    chk("bf_busy", 32'(busy), 32'd0);

    // Asynchronous reset while waiting for data.
    pc_addr  = 16'h0070;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    mem_gnt  = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("ar_pcinc_pre", 32'(pcinc), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_pcinc", 32'(pcinc), 32'd0);
    chk("ar_addr", 32'(mem_addr), 32'd0);
    chk("ar_ir", 32'(ir), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hCAFE;
    tick();
    mem_rvalid = 1'b0;
    tick();
    chk("ar_irv", 32'(ir_valid), 32'd0);
    chk("ar_ir_after", 32'(ir), 32'd0);
    chk("ar_busy_after", 32'(busy), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
